// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Scans NumCh ADC channels over a shared SPI master, one transfer per
// channel. Each result is presented with its channel tag. The block paces
// chip-select idle time between conversions and uses a watchdog to abort a
// hung transfer.
//
// Optional feature macro: ADC_SCAN_CONTINUOUS_EN
//   When defined, the block adds input cont_i. With cont_i=1 at the end of a
//   scan, it restarts at channel 0 without passing through IDLE.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           one-cycle scan trigger (accepted only in IDLE)
//   cont_i            continuous-scan enable (only with ADC_SCAN_CONTINUOUS_EN)
//   spi_start_o       one-cycle transfer request to the SPI master
//   spi_tx_o          command word {1'b1, ch, 12'b0}, held outside ISSUE
//   spi_done_i        transfer complete, spi_rx_i valid this cycle
//   spi_rx_i          received word
//   result_o          latched conversion result
//   result_ch_o       channel of result_o
//   result_valid_o    one-cycle pulse when result_o/result_ch_o update
//   busy_o            high whenever not IDLE
//   scan_done_o       one-cycle pulse as the last channel's settle completes
//   err_o             sticky watchdog flag, cleared by the next accepted start
module adc_scan_sequencer #(
    parameter int NumCh         = 8,
    parameter int DataW         = 12,
    parameter int SettleCycles  = 10,
    parameter int TimeoutCycles = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef ADC_SCAN_CONTINUOUS_EN
    input  logic             cont_i,
`endif
    output logic             spi_start_o,
    output logic [15:0]      spi_tx_o,
    input  logic             spi_done_i,
    input  logic [15:0]      spi_rx_i,
    output logic [DataW-1:0] result_o,
    output logic [2:0]       result_ch_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             scan_done_o,
    output logic             err_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int SW = $clog2(SettleCycles + 1);
    localparam logic [2:0] LastCh = 3'(NumCh - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [2:0]    ch, ch_n;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] settle_cnt;
    logic          tmo_end, settle_end;
    logic          done_acc, err_set, err_clr;

    // Upper received bits beyond DataW are intentionally dropped.
    logic unused_rx;
    assign unused_rx = &{1'b0, spi_rx_i};

    // Watchdog fires on the TimeoutCycles-th WAIT cycle.
    assign tmo_end = (tmo_cnt == TW'(TimeoutCycles - 1));
    // SETTLE lasts SettleCycles+1 cycles; the first overlaps result_valid_o.
    assign settle_end = (settle_cnt == SW'(SettleCycles));

    assign busy_o = (state != IDLE);

    always_comb begin
        state_n     = state;
        ch_n        = ch;
        spi_start_o = 1'b0;
        scan_done_o = 1'b0;
        done_acc    = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = ISSUE;
                    ch_n    = 3'd0;
                    err_clr = 1'b1;
                end
            end
            ISSUE: begin
                spi_start_o = 1'b1;
                state_n     = WAIT;
            end
            WAIT: begin
                // A done coinciding with expiry wins over the watchdog.
                if (spi_done_i) begin
                    done_acc = 1'b1;
                    state_n  = SETTLE;
                end else if (tmo_end) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    if (ch == LastCh) begin
                        scan_done_o = 1'b1;
`ifdef ADC_SCAN_CONTINUOUS_EN
                        if (cont_i) begin
                            state_n = ISSUE;
                            ch_n    = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
`else
                        state_n = IDLE;
`endif
                    end else begin
                        ch_n    = ch + 3'd1;
                        state_n = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ch             <= 3'd0;
            tmo_cnt        <= '0;
            settle_cnt     <= '0;
            spi_tx_o       <= 16'd0;
            result_o       <= '0;
            result_ch_o    <= 3'd0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            state          <= state_n;
            ch             <= ch_n;
            tmo_cnt        <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
            settle_cnt     <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
            result_valid_o <= done_acc;
            // Command is loaded on entry to ISSUE so it is stable during the
            // request and holds afterwards.
            if (state_n == ISSUE) spi_tx_o <= {1'b1, ch_n, 12'd0};
            if (done_acc) begin
                result_o    <= spi_rx_i[DataW-1:0];
                result_ch_o <= ch;
            end
            if (err_set)      err_o <= 1'b1;
            else if (err_clr) err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
module tb_adc_scan_sequencer;

    localparam int NUM_CH = 8;
    localparam int SETTLE = 10;
    localparam int TMO    = 1000;
    localparam int LAT    = 20;

    logic        clk, rst_i, start_i;
    logic        spi_start_o, spi_done_i;
    logic [15:0] spi_tx_o, spi_rx_i;
    logic [11:0] result_o;
    logic [2:0]  result_ch_o;
    logic        result_valid_o, busy_o, scan_done_o, err_o;
`ifdef ADC_SCAN_CONTINUOUS_EN
    logic        cont_i;
`endif

    // SPI model and stray-pulse injector drive separate terms.
    logic        m_done, s_done;
    logic [15:0] m_rx, s_rx;
    assign spi_done_i = m_done | s_done;
    assign spi_rx_i   = s_done ? s_rx : m_rx;

    adc_scan_sequencer #(
        .NumCh(NUM_CH), .DataW(12), .SettleCycles(SETTLE), .TimeoutCycles(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
`ifdef ADC_SCAN_CONTINUOUS_EN
        .cont_i(cont_i),
`endif
        .spi_start_o(spi_start_o), .spi_tx_o(spi_tx_o),
        .spi_done_i(spi_done_i), .spi_rx_i(spi_rx_i),
        .result_o(result_o), .result_ch_o(result_ch_o),
        .result_valid_o(result_valid_o), .busy_o(busy_o),
        .scan_done_o(scan_done_o), .err_o(err_o)
    );

    int nchk = 0, nfail = 0;
    int cyc = 0;
    int ndone = 0;
    int exp_done = 0;
    logic [15:0] exp_tx[$];
    logic [14:0] exp_res[$];   // {ch, data}
    bit          hold_en = 0;
    logic [2:0]  hold_ch = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_scan(input int ntx, input int nres, input bit done);
        for (int c = 0; c < ntx; c++) exp_tx.push_back(16'h8000 | 16'(c << 12));
        for (int c = 0; c < nres; c++) exp_res.push_back({3'(c), 12'hA00 + 12'(c)});
        if (done) exp_done++;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1;
        @(negedge clk); start_i = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_o && n < 3000) begin @(negedge clk); n++; end
        chk(nm, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic wait_result(input logic [2:0] c, input string nm);
        int n = 0;
        @(negedge clk);
        while (!(result_valid_o && result_ch_o == c) && n < 3000) begin @(negedge clk); n++; end
        chk(nm, {31'd0, result_valid_o}, 32'd1);
    endtask

    task automatic wait_tx(input logic [15:0] w, input string nm);
        int n = 0;
        @(negedge clk);
        while (!(spi_start_o && spi_tx_o == w) && n < 3000) begin @(negedge clk); n++; end
        chk(nm, {31'd0, spi_start_o}, 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_outs"}, {spi_start_o, result_valid_o, busy_o, scan_done_o, err_o,
                            result_ch_o, result_o, spi_tx_o}, 32'd0);
    endtask

    // SPI slave model: answers each request LAT cycles later with 0x0A00+ch.
    initial begin
        int pend = 0;
        logic [2:0] pch = 0;
        m_done = 0; m_rx = 0;
        forever begin
            @(negedge clk);
            m_done = 0;
            if (rst_i) pend = 0;
            else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin m_done = 1; m_rx = 16'h0A00 + 16'(pch); end
                end
                if (spi_start_o && !(hold_en && spi_tx_o[14:12] == hold_ch)) begin
                    pend = LAT; pch = spi_tx_o[14:12];
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        int last_v = -1;
        forever begin
            @(negedge clk);
            if (rst_i) last_v = -1;
            else begin
                if (spi_start_o) begin
                    if (exp_tx.size() == 0) chk("spi_start_unexpected", 32'd1, 32'd0);
                    else chk("spi_tx", {16'd0, spi_tx_o}, {16'd0, exp_tx.pop_front()});
                    if (last_v >= 0) chk("settle_gap", cyc - last_v, SETTLE + 1);
                    last_v = -1;
                end
                if (result_valid_o) begin
                    if (exp_res.size() == 0) chk("result_unexpected", {17'd0, result_ch_o, result_o}, 32'h7fff);
                    else chk("result", {17'd0, result_ch_o, result_o}, {17'd0, exp_res.pop_front()});
                    last_v = cyc;
                end
                if (scan_done_o) begin
                    ndone++;
                    if (exp_done == 0) chk("scan_done_unexpected", 32'd1, 32'd0);
                    else exp_done--;
                end
                if (!busy_o) last_v = -1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        start_i = 0; s_done = 0; s_rx = 0; rst_i = 0;
`ifdef ADC_SCAN_CONTINUOUS_EN
        cont_i = 0;
`endif
        #1 rst_i = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 0;

        // Full scan with ignored start pulses and a stray done in SETTLE.
        push_scan(NUM_CH, NUM_CH, 1);
        pulse_start();
        wait_result(3'd1, "wait_res1");
        pulse_start();
        wait_result(3'd2, "wait_res2");
        @(negedge clk); s_done = 1; s_rx = 16'h0BAD;
        @(negedge clk); s_done = 0;
        wait_idle("scan1_idle");
        chk("scan1_done_cnt", ndone, 1);
        chk("scan1_err", {31'd0, err_o}, 32'd0);

        // Watchdog on channel 3.
        hold_en = 1; hold_ch = 3'd3;
        push_scan(4, 3, 0);
        pulse_start();
        wait_tx(16'hB000, "wait_tx3");
        repeat (TMO) @(negedge clk);
        chk("wdog_busy_before", {30'd0, busy_o, err_o}, 32'd2);
        @(negedge clk);
        chk("wdog_fire", {30'd0, busy_o, err_o}, 32'd1);
        chk("wdog_no_done", ndone, 1);
        hold_en = 0;

        // Next start clears err and restarts at channel 0.
        push_scan(NUM_CH, NUM_CH, 1);
        pulse_start();
        chk("err_clear", {30'd0, busy_o, err_o}, 32'd2);
        wait_idle("scan2_idle");
        chk("scan2_done_cnt", ndone, 2);

        // Asynchronous reset while waiting on channel 5.
        push_scan(6, 5, 0);
        pulse_start();
        wait_tx(16'hD000, "wait_tx5");
        repeat (5) @(negedge clk);
        #2 rst_i = 1;
        #1 chk_all_zero("async_reset");
        @(negedge clk); rst_i = 0;
        chk("rst_queues", exp_tx.size() + exp_res.size(), 0);

        push_scan(NUM_CH, NUM_CH, 1);
        pulse_start();
        wait_idle("scan3_idle");
        chk("scan3_done_cnt", ndone, 3);

`ifdef ADC_SCAN_CONTINUOUS_EN
        cont_i = 1;
        push_scan(NUM_CH, NUM_CH, 1);
        push_scan(NUM_CH, NUM_CH, 1);
        pulse_start();
        s = 0;
        while (ndone < 4 && s < 3000) begin @(negedge clk); s++; end
        chk("cont_first_done", ndone, 4);
        chk("cont_busy", {31'd0, busy_o}, 32'd1);
        wait_result(3'd3, "cont_wait_res3");
        cont_i = 0;
        wait_idle("cont_idle");
        chk("cont_done_cnt", ndone, 5);
`endif

        repeat (5) @(negedge clk);
        chk("end_queues", exp_tx.size() + exp_res.size() + exp_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
